pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the fetch-side program counter of the MIPS soft core. It drives word addresses
//  to instruction memory over a valid/ready request handshake and advances sequentially
//  (+1 per word, word-addressed imem). It accepts redirects (exception, jr, j, taken
//  branch) from the execute/control path, and handles stall, halt and redirect-while-waiting.
// PARAMETERS
//  ADDR_W     32      PC / fetch address width (bits)
//  RESET_VEC  32'h0   word address loaded on reset
//  EXC_VEC    32'h20  word address loaded on exception redirect
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  stall        in   1       pipeline stall: do not issue a new fetch
//  halt         in   1       stop fetching until exception or reset
//  exc_req      in   1       exception redirect to EXC_VEC
//  jr_req       in   1       register jump; target = jr_target
//  jr_target    in   ADDR_W  word target for jr
//  j_req        in   1       absolute jump
//  j_index      in   26      j instr index
//  br_req       in   1       taken branch
//  br_pc        in   ADDR_W  PC of the branch instruction
//  br_off       in   16      signed word offset
//  fetch_addr   out  ADDR_W  current PC presented to imem
//  fetch_valid  out  1       request valid
//  fetch_ready  in   1       imem accepts request this cycle
//  fetch_kill   out  1       accepted request is wrong-path; decode must discard
//  halted       out  1       high while in HALT
// BEHAVIOUR
//  Reset: pc=RESET_VEC, state=BOOT, fetch_valid=0, fetch_kill=0, halted=0, pending=0.
//  Handshake: request accepted when fetch_valid&&fetch_ready. Once fetch_valid is high,
//   fetch_valid and fetch_addr stay stable until acceptance. stall/halt cannot retract it.
//  Redirect priority, same cycle: exc > jr > j > br. Targets:
//   exc=EXC_VEC; jr=jr_target; j={pc[31:26],j_index}; br=br_pc+1+sext(br_off).
//   All arithmetic mod 2^ADDR_W. pc+1 at 32'hFFFF_FFFF wraps to 0.
//  States:
//   BOOT : 1 cycle after reset, fetch_valid=0 -> REQ (IDLE if stall, HALT if halt).
//   REQ  : fetch_valid=1.
//          On accept: pc<=redirect target if redirect now, else pending target if
//          pending, else pc+1. Clear pending.
//          Next state: HALT if halt (and no exc), IDLE if stall, else REQ.
//          Not accepted with a redirect: latch the highest-priority target into pending.
//          A later redirect overwrites pending only if its priority >= pending's.
//          On acceptance with pending set (redirect arrived before accept), fetch_kill=1
//          that cycle. A redirect in the accept cycle itself gives fetch_kill=0.
//   IDLE : fetch_valid=0. A redirect loads pc directly (no kill).
//          !stall -> REQ; halt -> HALT.
//   HALT : fetch_valid=0, halted=1. Only exc_req leaves: pc<=EXC_VEC -> REQ.
//          All other redirects ignored.
//  fetch_kill is a 1-cycle pulse aligned with the accept cycle; 0 otherwise.
//  Reset at any time, including mid-request, returns to the reset state next edge;
//   pending is dropped.
//  Latency: redirect seen in IDLE/REQ-accept cycle -> fetch_addr=target next cycle.
// STRUCTURE
//  pc_pkg: state enum {BOOT,IDLE,REQ,HALT}, redirect priority enum
//   {NONE,BR,J,JR,EXC}, vector defaults.
//  Sub-module pc_next_mux: combinational priority select + target arithmetic
//   (outputs redir_valid, redir_prio, redir_target). Instantiated once.
// TESTING
//  1 rst 3 cyc, ready=1 -> BOOT 1 cyc, fetch_addr 0,1,2,3 on consecutive cycles, kill=0.
//  2 pc=5, ready=0 for 3 cyc -> addr held at 5, valid=1. stall=1 meanwhile does not drop valid.
//    Then ready=1 -> next addr 6.
//  3 pc=10 waiting; br_req (br_pc=8, off=-3) then jr_req target 0x40 next cycle
//    -> on accept fetch_kill=1, next addr 0x40. Lower prio br later does not overwrite.
//  4 j_req, j_index=0x100, and exc_req same cycle in REQ-accept -> next addr 0x20, kill=0.
//  5 halt=1 at accept -> halted=1, valid=0. jr_req ignored. exc_req -> addr 0x20, valid=1.
//  6 pc=32'hFFFF_FFFF accepted -> next addr 0. rst mid-wait -> addr 0, valid=0 next cycle.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the fetch-side program counter: FSM states, redirect
// priorities (ordered so a numeric compare gives precedence) and vector defaults.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        IDLE = 2'd1,
        REQ  = 2'd2,
        HALT = 2'd3
    } pc_state_e;

    // Higher encoding wins when two redirects compete.
    typedef enum logic [2:0] {
        PRIO_NONE = 3'd0,
        PRIO_BR   = 3'd1,
        PRIO_J    = 3'd2,
        PRIO_JR   = 3'd3,
        PRIO_EXC  = 3'd4
    } redir_prio_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0020;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational redirect select: picks the highest-priority redirect request
// and computes its word-address target.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(DEF_EXC_VEC)
) (
    input  logic [ADDR_W-27:0] i_pcHigh,
    input  logic               i_excReq,
    input  logic               i_jrReq,
    input  logic [ADDR_W-1:0]  i_jrTarget,
    input  logic               i_jReq,
    input  logic [25:0]        i_jIndex,
    input  logic               i_brReq,
    input  logic [ADDR_W-1:0]  i_brPc,
    input  logic [15:0]        i_brOff,
    output logic               o_redirValid,
    output redir_prio_e        o_redirPrio,
    output logic [ADDR_W-1:0]  o_redirTarget
);

    logic [ADDR_W-1:0] w_brOffExt;
    logic [ADDR_W-1:0] w_brTarget;

    assign w_brOffExt = {{(ADDR_W-16){i_brOff[15]}}, i_brOff};
    assign w_brTarget = i_brPc + ADDR_W'(1) + w_brOffExt;

    always_comb begin
        o_redirValid  = 1'b0;
        o_redirPrio   = PRIO_NONE;
        o_redirTarget = '0;
        if (i_excReq) begin
            o_redirValid  = 1'b1;
            o_redirPrio   = PRIO_EXC;
            o_redirTarget = EXC_VEC;
        end else if (i_jrReq) begin
            o_redirValid  = 1'b1;
            o_redirPrio   = PRIO_JR;
            o_redirTarget = i_jrTarget;
        end else if (i_jReq) begin
            o_redirValid  = 1'b1;
            o_redirPrio   = PRIO_J;
            o_redirTarget = {i_pcHigh, i_jIndex};
        end else if (i_brReq) begin
            o_redirValid  = 1'b1;
            o_redirPrio   = PRIO_BR;
            o_redirTarget = w_brTarget;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side program counter: issues word addresses to imem over valid/ready,
// and folds in redirects, stalls and halt, remembering redirects that arrive mid-request.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              exc_req,
    input  logic              jr_req,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              j_req,
    input  logic [25:0]       j_index,
    input  logic              br_req,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [15:0]       br_off,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic              fetch_kill,
    output logic              halted
);

    pc_state_e         r_state;
    logic [ADDR_W-1:0] r_pc;
    redir_prio_e       r_pendPrio;
    logic [ADDR_W-1:0] r_pendTarget;

    pc_state_e         w_stateNext;
    logic [ADDR_W-1:0] w_pcNext;
    redir_prio_e       w_pendPrioNext;
    logic [ADDR_W-1:0] w_pendTargetNext;
    logic              w_pendValid;
    logic              w_redirValid;
    redir_prio_e       w_redirPrio;
    logic [ADDR_W-1:0] w_redirTarget;

    pc_next_mux #(
        .ADDR_W  (ADDR_W),
        .EXC_VEC (EXC_VEC)
    ) u_nextMux (
        .i_pcHigh      (r_pc[ADDR_W-1:26]),
        .i_excReq      (exc_req),
        .i_jrReq       (jr_req),
        .i_jrTarget    (jr_target),
        .i_jReq        (j_req),
        .i_jIndex      (j_index),
        .i_brReq       (br_req),
        .i_brPc        (br_pc),
        .i_brOff       (br_off),
        .o_redirValid  (w_redirValid),
        .o_redirPrio   (w_redirPrio),
        .o_redirTarget (w_redirTarget)
    );

    assign w_pendValid = (r_pendPrio != PRIO_NONE);
    assign fetch_addr  = r_pc;

    always_comb begin
        w_stateNext      = r_state;
        w_pcNext         = r_pc;
        w_pendPrioNext   = r_pendPrio;
        w_pendTargetNext = r_pendTarget;
        fetch_valid      = 1'b0;
        fetch_kill       = 1'b0;
        halted           = 1'b0;
        case (r_state)
            BOOT: begin
                if (halt)       w_stateNext = HALT;
                else if (stall) w_stateNext = IDLE;
                else            w_stateNext = REQ;
            end
            REQ: begin
                fetch_valid = 1'b1;
                if (fetch_ready) begin
                    // The in-flight word was fetched before a pending redirect was known.
                    fetch_kill     = w_pendValid;
                    w_pendPrioNext = PRIO_NONE;
                    if (w_redirValid)     w_pcNext = w_redirTarget;
                    else if (w_pendValid) w_pcNext = r_pendTarget;
                    else                  w_pcNext = r_pc + ADDR_W'(1);
                    if (halt && !exc_req) w_stateNext = HALT;
                    else if (stall)       w_stateNext = IDLE;
                    else                  w_stateNext = REQ;
                end else if (w_redirValid && (w_redirPrio >= r_pendPrio)) begin
                    w_pendPrioNext   = w_redirPrio;
                    w_pendTargetNext = w_redirTarget;
                end
            end
            IDLE: begin
                if (w_redirValid) w_pcNext = w_redirTarget;
                if (halt && !exc_req) w_stateNext = HALT;
                else if (!stall)      w_stateNext = REQ;
            end
            HALT: begin
                halted = 1'b1;
                if (exc_req) begin
                    w_pcNext    = EXC_VEC;
                    w_stateNext = REQ;
                end
            end
            default: w_stateNext = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= BOOT;
            r_pc         <= RESET_VEC;
            r_pendPrio   <= PRIO_NONE;
            r_pendTarget <= '0;
        end else begin
            r_state      <= w_stateNext;
            r_pc         <= w_pcNext;
            r_pendPrio   <= w_pendPrioNext;
            r_pendTarget <= w_pendTargetNext;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: inputs driven on the falling edge, outputs
// checked 1ns later against hand-computed values.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        halt;
    logic        exc_req;
    logic        jr_req;
    logic [31:0] jr_target;
    logic        j_req;
    logic [25:0] j_index;
    logic        br_req;
    logic [31:0] br_pc;
    logic [15:0] br_off;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        fetch_kill;
    logic        halted;

    int checkCount = 0;
    int errorCount = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .halt        (halt),
        .exc_req     (exc_req),
        .jr_req      (jr_req),
        .jr_target   (jr_target),
        .j_req       (j_req),
        .j_index     (j_index),
        .br_req      (br_req),
        .br_pc       (br_pc),
        .br_off      (br_off),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_kill  (fetch_kill),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Waits for the falling edge, then drives the control inputs with all redirects cleared.
    task automatic applyStimulus(input logic iRst, input logic iStall, input logic iHalt,
                                 input logic iReady);
        @(negedge clk);
        rst         = iRst;
        stall       = iStall;
        halt        = iHalt;
        fetch_ready = iReady;
        exc_req     = 1'b0;
        jr_req      = 1'b0;
        j_req       = 1'b0;
        br_req      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; halt = 1'b0; fetch_ready = 1'b1;
        exc_req = 1'b0; jr_req = 1'b0; j_req = 1'b0; br_req = 1'b0;
        jr_target = '0; j_index = '0; br_pc = '0; br_off = '0;
        repeat (3) @(posedge clk);

        $display("[TB] reset and sequential fetch");
        applyStimulus(0, 0, 0, 1); #1;
        checkOutput("boot_valid", 32'(fetch_valid), 32'd0);
        checkOutput("boot_addr", fetch_addr, 32'h0);
        checkOutput("boot_halted", 32'(halted), 32'd0);
        checkOutput("boot_kill", 32'(fetch_kill), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1); #1;
            checkOutput("seq_valid", 32'(fetch_valid), 32'd1);
            checkOutput("seq_addr", fetch_addr, 32'(i));
            checkOutput("seq_kill", 32'(fetch_kill), 32'd0);
        end

        $display("[TB] backpressure hold");
        applyStimulus(0, 0, 0, 1); #1;
        checkOutput("pre_hold_addr", fetch_addr, 32'h4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, (i > 0), 0, 0); #1;
            checkOutput("hold_addr", fetch_addr, 32'h5);
            checkOutput("hold_valid", 32'(fetch_valid), 32'd1);
        end
        applyStimulus(0, 0, 0, 1); #1;
        checkOutput("hold_accept_kill", 32'(fetch_kill), 32'd0);
        applyStimulus(0, 0, 0, 1); #1;
        checkOutput("after_hold_addr", fetch_addr, 32'h6);

        $display("[TB] pending redirect with kill");
        applyStimulus(0, 0, 0, 1);
        jr_req = 1'b1; jr_target = 32'h0000_000A; #1;
        checkOutput("jr_accept_kill", 32'(fetch_kill), 32'd0);
        applyStimulus(0, 0, 0, 0);
        br_req = 1'b1; br_pc = 32'h8; br_off = 16'hFFFD; #1;
        checkOutput("jr_latency_addr", fetch_addr, 32'h0000_000A);
        applyStimulus(0, 0, 0, 0);
        jr_req = 1'b1; jr_target = 32'h0000_0040; #1;
        checkOutput("wait_kill", 32'(fetch_kill), 32'd0);
        applyStimulus(0, 0, 0, 0);
        br_req = 1'b1; #1;
        checkOutput("wait_addr", fetch_addr, 32'h0000_000A);
        applyStimulus(0, 0, 0, 1); #1;
        checkOutput("pend_kill", 32'(fetch_kill), 32'd1);
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("pend_target", fetch_addr, 32'h0000_0040);
        checkOutput("pend_kill_clear", 32'(fetch_kill), 32'd0);

        $display("[TB] exc beats j in accept cycle");
        applyStimulus(0, 0, 0, 1);
        j_req = 1'b1; j_index = 26'h100; exc_req = 1'b1; #1;
        checkOutput("exc_j_kill", 32'(fetch_kill), 32'd0);
        applyStimulus(0, 0, 1, 1); #1;
        checkOutput("exc_addr", fetch_addr, 32'h0000_0020);
        checkOutput("pre_halt_halted", 32'(halted), 32'd0);

        $display("[TB] halt");
        applyStimulus(0, 0, 1, 1);
        jr_req = 1'b1; jr_target = 32'h0000_0099; #1;
        checkOutput("halt_halted", 32'(halted), 32'd1);
        checkOutput("halt_valid", 32'(fetch_valid), 32'd0);
        applyStimulus(0, 0, 1, 1);
        exc_req = 1'b1; #1;
        checkOutput("halt_jr_ignored", fetch_addr, 32'h0000_0021);
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("unhalt_addr", fetch_addr, 32'h0000_0020);
        checkOutput("unhalt_valid", 32'(fetch_valid), 32'd1);
        checkOutput("unhalt_halted", 32'(halted), 32'd0);

        $display("[TB] idle redirects and wrap");
        applyStimulus(0, 1, 0, 1); #1;
        applyStimulus(0, 1, 0, 1);
        jr_req = 1'b1; jr_target = 32'hFFFF_FFFF; #1;
        checkOutput("idle_valid", 32'(fetch_valid), 32'd0);
        checkOutput("idle_addr", fetch_addr, 32'h0000_0021);
        applyStimulus(0, 1, 0, 1);
        j_req = 1'b1; j_index = 26'h100; #1;
        checkOutput("idle_jr_addr", fetch_addr, 32'hFFFF_FFFF);
        applyStimulus(0, 1, 0, 1);
        jr_req = 1'b1; jr_target = 32'hFFFF_FFFF; #1;
        checkOutput("j_target_addr", fetch_addr, 32'hFC00_0100);
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("idle_exit_valid", 32'(fetch_valid), 32'd0);
        applyStimulus(0, 0, 0, 1); #1;
        checkOutput("wrap_pre_addr", fetch_addr, 32'hFFFF_FFFF);
        applyStimulus(0, 0, 0, 1);
        br_req = 1'b1; br_pc = 32'h10; br_off = 16'hFFFD; #1;
        checkOutput("wrap_addr", fetch_addr, 32'h0);
        applyStimulus(0, 0, 0, 1); #1;
        checkOutput("br_target_addr", fetch_addr, 32'h0000_000E);

        $display("[TB] reset mid-wait");
        applyStimulus(0, 0, 0, 0);
        br_req = 1'b1; br_pc = 32'h10; br_off = 16'h0; #1;
        checkOutput("rst_wait_addr", fetch_addr, 32'h0000_000F);
        applyStimulus(1, 0, 0, 0); #1;
        applyStimulus(0, 0, 0, 1); #1;
        checkOutput("rst_valid", 32'(fetch_valid), 32'd0);
        checkOutput("rst_addr", fetch_addr, 32'h0);
        applyStimulus(0, 0, 0, 1); #1;
        checkOutput("rst_pend_dropped_kill", 32'(fetch_kill), 32'd0);
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("rst_seq_addr", fetch_addr, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
